hbridge_pwm_driver: RTL and testbench
=====================================

Name: hbridge_pwm_driver

Overview:
Parametrised N-channel PWM driver for L293-class H-bridges. It is the successor to the fixed two-motor controller, replacing its constant sign/upper-limit inputs with per-channel signed duty commands. Adds period-synchronous duty update, slew (ramp) limiting, dead time on direction reversal, and active braking. Sits between the balance-control loop and the bridge pins; clocked from the divided HSOSC domain.

Parameters:
N_CH, 2, number of motor channels
WIDTH, 7, duty command width in bits
PERIOD, 100, PWM period in ticks; must satisfy 2 <= PERIOD <= 2^WIDTH
CLK_DIV, 1, clk cycles per PWM tick (1 = every cycle)
DEAD_PERIODS, 2, full PWM periods of bridge-off inserted on direction reversal
RAMP_STEP, 0, max change of active duty per period; 0 = no ramp (jump straight to target)

Ports:
clk  in  1  system clock (divided HSOSC)
reset  in  1  synchronous, active-high reset
sign  in  N_CH  per-channel direction request (1 = forward: a=1, b=0)
duty  in  N_CH*WIDTH  per-channel duty in ticks; channel i occupies bits [i*WIDTH +: WIDTH]
brake  in  N_CH  per-channel brake request
enable  out  N_CH  bridge enable (PWM output)
in_a  out  N_CH  bridge input A
in_b  out  N_CH  bridge input B
period_start  out  1  one-clk pulse on each PWM period wrap
dead_active  out  N_CH  channel is currently in dead time (debug light)

Behaviour:
- Reset, on the next clk edge while high: prescaler=0, pwm_cnt=0, every channel in RUN with act_duty=0 and act_sign=0; all outputs 0. Reset mid-period aborts the period, ramp and dead time immediately.
- Prescaler counts 0..CLK_DIV-1. tick = (prescaler==CLK_DIV-1). pwm_cnt advances on tick, 0..PERIOD-1, then wraps.
- boundary = tick && pwm_cnt==PERIOD-1. period_start is registered and high for exactly the one clk cycle after the boundary.
- Inputs are sampled only at boundary. Changes mid-period have no effect until the next boundary (glitch-free). Exception: brake.
- Target duty tgt = min(duty[i], PERIOD).
- Per-channel state machine, evaluated at boundary:
  - RUN, sign[i]==act_sign: act_duty steps toward tgt. If RAMP_STEP==0, act_duty=tgt. Otherwise act_duty changes by min(|tgt-act_duty|, RAMP_STEP) in the correct direction. No overshoot.
  - RUN, sign[i]!=act_sign, act_duty==0: act_sign=sign[i] immediately, no dead time. Ramp then begins from 0.
  - RUN, sign[i]!=act_sign, act_duty!=0: go to DEAD, act_duty=0, dead_cnt=DEAD_PERIODS-1. If DEAD_PERIODS==0, the reversal behaves like the act_duty==0 case.
  - DEAD: if dead_cnt==0, act_sign=sign[i] as sampled at this boundary, then RUN. Ramp restarts from 0 toward tgt at the following boundaries. Otherwise dead_cnt decrements. Direction requests received during DEAD are re-evaluated only at exit.
- Brake overrides everything and takes effect at the first clk edge where brake[i]=1, not at a boundary.
  - Forces act_duty=0 and state RUN; cancels DEAD.
  - Outputs enable=1, in_a=0, in_b=0.
  - On release, the channel resumes RUN from act_duty=0 at the next boundary. act_sign is kept.
- Output mapping, all registered, 1 clk latency from the pwm_cnt value:
  - RUN, no brake: enable = (pwm_cnt < act_duty); in_a = act_sign; in_b = ~act_sign.
  - DEAD: enable=0, in_a=0, in_b=0, dead_active=1.
  - in_a and in_b are never both 1.
- Duty boundary cases:
  - act_duty=0: enable never high.
  - act_duty=PERIOD: enable high for the whole period.
  - duty > PERIOD: clamped to PERIOD.
- Channels are independent. Simultaneous boundary and brake on the same channel: brake wins.

Test Plan:
- Defaults, CLK_DIV=1. reset 2 cycles, sign=2'b01, ch0 duty=25, ch1 duty=50 -> after the first boundary, ch0 enable high 25 of every 100 cycles and ch1 high 50. ch0 in_a=1/in_b=0; ch1 in_a=0/in_b=1. period_start every 100 cycles.
- ch0 running at duty=25, flip sign[0] to 0 mid-period -> no change until the boundary. Then 2 periods with enable=in_a=in_b=0 and dead_active[0]=1. Then in_b=1 with duty 25.
- ch0 duty=127 -> clamped; enable continuously high. duty=0 -> enable continuously low; a sign flip here applies at the next boundary with no dead time.
- RAMP_STEP=10, duty 0->35 -> act_duty 10, 20, 30, 35 over 4 consecutive periods. Then 35->5 gives 25, 15, 5.
- Assert brake[1] mid-period during dead time -> next clk enable[1]=1, in_a=in_b=0, dead_active=0. Release -> ramps from 0 starting at the next boundary.
- Assert reset mid-period with both channels active -> next clk all outputs 0 and pwm_cnt=0. After release, first period_start occurs 100 cycles later.

Source files
------------

// File: rtl/hbridge_pwm_driver.sv
// hbridge_pwm_driver
//   N-channel PWM driver for L293-class H-bridges. Each channel takes a signed
//   duty command (sign + magnitude), applies it only at PWM period boundaries,
//   optionally slew-limits it, inserts whole periods of bridge-off on a
//   direction reversal, and supports immediate active braking.
//
// Ports
//   clk            system clock (divided HSOSC)
//   reset          synchronous, active-high reset
//   sign[N_CH]     direction request per channel (1 = forward: a=1, b=0)
//   duty[N_CH*W]   duty in ticks, channel i at [i*WIDTH +: WIDTH]
//   brake[N_CH]    brake request, acts on the next clk edge
//   enable[N_CH]   bridge enable (PWM)
//   in_a/in_b      bridge direction inputs, never both high
//   period_start   one-clk pulse after every PWM period wrap
//   dead_active    channel is inside reversal dead time
//
// Channel states
//   state   | meaning
//   ST_RUN  | normal PWM at act_duty in direction act_sign
//   ST_DEAD | bridge off for DEAD_PERIODS periods before a reversal
module hbridge_pwm_driver #(
  parameter int N_CH         = 2,
  parameter int WIDTH        = 7,
  parameter int PERIOD       = 100,
  parameter int CLK_DIV      = 1,
  parameter int DEAD_PERIODS = 2,
  parameter int RAMP_STEP    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       sign,
  input  logic [N_CH*WIDTH-1:0] duty,
  input  logic [N_CH-1:0]       brake,
  output logic [N_CH-1:0]       enable,
  output logic [N_CH-1:0]       in_a,
  output logic [N_CH-1:0]       in_b,
  output logic                  period_start,
  output logic [N_CH-1:0]       dead_active
);

  // act_duty may equal PERIOD, which can be 2^WIDTH, so it needs one extra bit.
  localparam int DW        = WIDTH + 1;
  localparam int PSW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DCW       = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam int RS_C      = (RAMP_STEP > PERIOD) ? PERIOD : RAMP_STEP;
  localparam int DEAD_INIT = (DEAD_PERIODS > 0) ? DEAD_PERIODS - 1 : 0;

  localparam logic [PSW-1:0]   PS_LAST   = PSW'(CLK_DIV - 1);
  localparam logic [WIDTH-1:0] CNT_LAST  = WIDTH'(PERIOD - 1);
  localparam logic [DW-1:0]    PERIOD_D  = DW'(PERIOD);
  localparam logic [DW-1:0]    RAMP_D    = DW'(RS_C);
  localparam logic [DCW-1:0]   DEAD_LOAD = DCW'(DEAD_INIT);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } ch_state_e;

  logic [PSW-1:0]   presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick, boundary;
  logic             ps_q;

  ch_state_e        state_q [N_CH];
  ch_state_e        state_d [N_CH];
  logic [DW-1:0]    act_q   [N_CH];
  logic [DW-1:0]    act_d   [N_CH];
  logic [DCW-1:0]   dcnt_q  [N_CH];
  logic [DCW-1:0]   dcnt_d  [N_CH];
  logic [DW-1:0]    tgt     [N_CH];
  logic [N_CH-1:0]  sgn_q, sgn_d;

  logic [N_CH-1:0]  en_q, en_d;
  logic [N_CH-1:0]  a_q, a_d;
  logic [N_CH-1:0]  b_q, b_d;
  logic [N_CH-1:0]  dead_q, dead_d;

  function automatic logic [DW-1:0] clamp_duty(input logic [WIDTH-1:0] d);
    return ({1'b0, d} > PERIOD_D) ? PERIOD_D : {1'b0, d};
  endfunction

  // One slew-limited step from cur toward tgt_v; never overshoots.
  function automatic logic [DW-1:0] ramp_to(input logic [DW-1:0] cur,
                                            input logic [DW-1:0] tgt_v);
    logic [DW-1:0] diff;
    if (RS_C == 0) return tgt_v;
    if (tgt_v >= cur) begin
      diff = tgt_v - cur;
      return (diff > RAMP_D) ? cur + RAMP_D : tgt_v;
    end
    diff = cur - tgt_v;
    return (diff > RAMP_D) ? cur - RAMP_D : tgt_v;
  endfunction

  always_comb begin
    tick     = (presc_q == PS_LAST);
    boundary = tick && (cnt_q == CNT_LAST);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    cnt_d    = cnt_q;
    if (tick) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    sgn_d  = sgn_q;
    en_d   = '0;
    a_d    = '0;
    b_d    = '0;
    dead_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      act_d[i]   = act_q[i];
      dcnt_d[i]  = dcnt_q[i];
      tgt[i]     = clamp_duty(duty[i*WIDTH +: WIDTH]);

      // Brake is asynchronous to the period: it wins over any boundary update.
      if (brake[i]) begin
        state_d[i] = ST_RUN;
        act_d[i]   = '0;
        dcnt_d[i]  = '0;
      end else if (boundary) begin
        case (state_q[i])
          ST_RUN: begin
            if (sign[i] == sgn_q[i]) begin
              act_d[i] = ramp_to(act_q[i], tgt[i]);
            end else if (act_q[i] == '0 || DEAD_PERIODS == 0) begin
              // Bridge already idle (or no dead time wanted): reverse now and
              // take the first ramp step from zero in the new direction.
              sgn_d[i] = sign[i];
              act_d[i] = ramp_to('0, tgt[i]);
            end else begin
              state_d[i] = ST_DEAD;
              act_d[i]   = '0;
              dcnt_d[i]  = DEAD_LOAD;
            end
          end
          ST_DEAD: begin
            // Direction is re-read only here, so requests made during the
            // dead time never shorten it. Duty stays 0 for this period.
            if (dcnt_q[i] == '0) begin
              sgn_d[i]   = sign[i];
              state_d[i] = ST_RUN;
            end else begin
              dcnt_d[i] = dcnt_q[i] - 1'b1;
            end
          end
          default: state_d[i] = ST_RUN;
        endcase
      end

      if (brake[i]) begin
        en_d[i] = 1'b1;
      end else if (state_q[i] == ST_DEAD) begin
        dead_d[i] = 1'b1;
      end else begin
        en_d[i] = ({1'b0, cnt_q} < act_q[i]);
        a_d[i]  = sgn_q[i];
        b_d[i]  = ~sgn_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      cnt_q   <= '0;
      ps_q    <= 1'b0;
      sgn_q   <= '0;
      en_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dead_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_RUN;
        act_q[i]   <= '0;
        dcnt_q[i]  <= '0;
      end
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      ps_q    <= boundary;
      sgn_q   <= sgn_d;
      en_q    <= en_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dead_q  <= dead_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        act_q[i]   <= act_d[i];
        dcnt_q[i]  <= dcnt_d[i];
      end
    end
  end

  assign enable       = en_q;
  assign in_a         = a_q;
  assign in_b         = b_q;
  assign dead_active  = dead_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_hbridge_pwm_driver.sv
// Bench for hbridge_pwm_driver: two instances (jump / ramped + divided clock)
// driven with the same stimulus, each checked every cycle against a
// period-level behavioural model, plus directed literal checks.
module tb_hbridge_pwm_driver;
  localparam int NCH = 2;
  localparam int W   = 7;
  localparam int P   = 100;

  function automatic int cd_of(input int k); return (k == 0) ? 1 : 3;  endfunction
  function automatic int dp_of(input int k); return (k == 0) ? 2 : 1;  endfunction
  function automatic int rs_of(input int k); return (k == 0) ? 0 : 10; endfunction

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] sign_s, brake_s;
  logic [NCH*W-1:0] duty_s;
  logic [NCH-1:0] en0, ia0, ib0, dd0, en1, ia1, ib1, dd1;
  logic           ps0, ps1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hbridge_pwm_driver #(.N_CH(NCH), .WIDTH(W), .PERIOD(P), .CLK_DIV(1),
                       .DEAD_PERIODS(2), .RAMP_STEP(0)) u_dut0 (
    .clk(clk), .reset(reset), .sign(sign_s), .duty(duty_s), .brake(brake_s),
    .enable(en0), .in_a(ia0), .in_b(ib0), .period_start(ps0), .dead_active(dd0));

  hbridge_pwm_driver #(.N_CH(NCH), .WIDTH(W), .PERIOD(P), .CLK_DIV(3),
                       .DEAD_PERIODS(1), .RAMP_STEP(10)) u_dut1 (
    .clk(clk), .reset(reset), .sign(sign_s), .duty(duty_s), .brake(brake_s),
    .enable(en1), .in_a(ia1), .in_b(ib1), .period_start(ps1), .dead_active(dd1));

  // ---------------- behavioural model ----------------
  int m_c    [2];
  int m_duty [2][NCH];
  bit m_sgn  [2][NCH];
  int m_dead [2][NCH];   // dead periods still to run, 0 = running
  bit m_valid = 1'b0;
  logic [NCH-1:0] e_en [2];
  logic [NCH-1:0] e_a  [2];
  logic [NCH-1:0] e_b  [2];
  logic [NCH-1:0] e_d  [2];
  logic           e_ps [2];

  function automatic int step_to(input int cur, input int tgt, input int rs);
    if (rs == 0) return tgt;
    if (tgt > cur) return (cur + rs < tgt) ? cur + rs : tgt;
    return (cur - rs > tgt) ? cur - rs : tgt;
  endfunction

  initial begin
    int cyc, pwm, tgt;
    bit bnd;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          m_c[k] = 0;
          e_en[k] = '0; e_a[k] = '0; e_b[k] = '0; e_d[k] = '0; e_ps[k] = 1'b0;
          for (int i = 0; i < NCH; i++) begin
            m_duty[k][i] = 0; m_sgn[k][i] = 1'b0; m_dead[k][i] = 0;
          end
        end else begin
          cyc = cd_of(k) * P;
          pwm = (m_c[k] / cd_of(k)) % P;
          bnd = ((m_c[k] % cyc) == cyc - 1);
          e_ps[k] = bnd;
          for (int i = 0; i < NCH; i++) begin
            if (brake_s[i]) begin
              e_en[k][i] = 1'b1; e_a[k][i] = 1'b0; e_b[k][i] = 1'b0; e_d[k][i] = 1'b0;
            end else if (m_dead[k][i] > 0) begin
              e_en[k][i] = 1'b0; e_a[k][i] = 1'b0; e_b[k][i] = 1'b0; e_d[k][i] = 1'b1;
            end else begin
              e_en[k][i] = (pwm < m_duty[k][i]);
              e_a[k][i]  = m_sgn[k][i];
              e_b[k][i]  = !m_sgn[k][i];
              e_d[k][i]  = 1'b0;
            end
            tgt = int'(duty_s[i*W +: W]);
            if (tgt > P) tgt = P;
            if (brake_s[i]) begin
              m_duty[k][i] = 0;
              m_dead[k][i] = 0;
            end else if (bnd) begin
              if (m_dead[k][i] > 0) begin
                m_dead[k][i] = m_dead[k][i] - 1;
                if (m_dead[k][i] == 0) m_sgn[k][i] = sign_s[i];
              end else if (sign_s[i] == m_sgn[k][i]) begin
                m_duty[k][i] = step_to(m_duty[k][i], tgt, rs_of(k));
              end else if (m_duty[k][i] == 0 || dp_of(k) == 0) begin
                m_sgn[k][i]  = sign_s[i];
                m_duty[k][i] = step_to(0, tgt, rs_of(k));
              end else begin
                m_dead[k][i] = dp_of(k);
                m_duty[k][i] = 0;
              end
            end
          end
          m_c[k] = (m_c[k] + 1) % cyc;
        end
      end
      if (reset) m_valid = 1'b1;
    end
  end

  function automatic logic [4*NCH:0] outs(input int k);
    return (k == 0) ? {ps0, en0, ia0, ib0, dd0} : {ps1, en1, ia1, ib1, dd1};
  endfunction

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [4*NCH:0] act, req;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        for (int k = 0; k < 2; k++) begin
          act = outs(k);
          req = {e_ps[k], e_en[k], e_a[k], e_b[k], e_d[k]};
          n_chk++;
          if (act !== req) begin
            n_fail++;
            if (n_fail <= 20)
              $display("FAIL cycle_cmp dut%0d t=%0t actual {ps,en,a,b,dead}=%b required=%b",
                       k, $time, act, req);
          end
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  int r_en[NCH], r_a[NCH], r_b[NCH], r_d[NCH], r_ps;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic wait_ps(input int k);
    int budget;
    logic [4*NCH:0] v;
    budget = 0;
    v = outs(k);
    while (!v[4*NCH] && budget < 4 * cd_of(k) * P) begin
      @(negedge clk);
      budget++;
      v = outs(k);
    end
    if (!v[4*NCH]) begin
      n_chk++; n_fail++;
      $display("FAIL wait_period_start dut%0d timeout actual=0 required=1", k);
    end
  endtask

  // Counts output-high cycles over the PWM period that starts at the current
  // period_start pulse.
  task automatic measure(input int k);
    logic [4*NCH:0] v;
    wait_ps(k);
    r_ps = 0;
    for (int i = 0; i < NCH; i++) begin r_en[i] = 0; r_a[i] = 0; r_b[i] = 0; r_d[i] = 0; end
    for (int j = 0; j < cd_of(k) * P; j++) begin
      @(negedge clk);
      v = outs(k);
      r_ps += int'(v[4*NCH]);
      for (int i = 0; i < NCH; i++) begin
        r_d[i]  += int'(v[i]);
        r_b[i]  += int'(v[NCH + i]);
        r_a[i]  += int'(v[2*NCH + i]);
        r_en[i] += int'(v[3*NCH + i]);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4*NCH:0] v;
    int n, ch;
    bit s0, s1;
    int ramp_exp[8];
    ramp_exp = '{10, 20, 30, 35, 35, 25, 15, 5};
    reset = 1'b1; sign_s = '0; duty_s = '0; brake_s = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs_dut0", int'(outs(0)), 0);
    chk("reset_outs_dut1", int'(outs(1)), 0);
    sign_s = 2'b01;
    duty_s = {7'd50, 7'd25};
    reset  = 1'b0;

    // Basic duty and direction
    measure(0);
    chk("basic_en_ch0", r_en[0], 25);
    chk("basic_en_ch1", r_en[1], 50);
    chk("basic_a_ch0", r_a[0], 100);
    chk("basic_b_ch0", r_b[0], 0);
    chk("basic_a_ch1", r_a[1], 0);
    chk("basic_b_ch1", r_b[1], 100);
    chk("basic_ps_per_period", r_ps, 1);

    // Reversal with dead time on ch0
    repeat (30) @(negedge clk);
    sign_s = 2'b00;
    measure(0);
    chk("dead1_dead_ch0", r_d[0], 100);
    chk("dead1_en_ch0", r_en[0] + r_a[0] + r_b[0], 0);
    chk("dead1_en_ch1", r_en[1], 50);
    measure(0);
    chk("dead2_dead_ch0", r_d[0], 100);
    chk("dead2_en_ch0", r_en[0] + r_a[0] + r_b[0], 0);
    measure(0);
    chk("dead_exit_dead_ch0", r_d[0], 0);
    chk("dead_exit_en_ch0", r_en[0], 0);
    chk("dead_exit_b_ch0", r_b[0], 100);
    measure(0);
    chk("rev_en_ch0", r_en[0], 25);
    chk("rev_b_ch0", r_b[0], 100);

    // Clamp, zero duty, zero-duty reversal
    repeat (20) @(negedge clk);
    duty_s = {7'd50, 7'd127};
    measure(0);
    chk("clamp_en_ch0", r_en[0], 100);
    repeat (20) @(negedge clk);
    duty_s = {7'd50, 7'd0};
    measure(0);
    chk("zero_en_ch0", r_en[0], 0);
    repeat (20) @(negedge clk);
    sign_s = 2'b01;
    measure(0);
    chk("zero_flip_a_ch0", r_a[0], 100);
    chk("zero_flip_dead_ch0", r_d[0], 0);
    chk("zero_flip_en_ch0", r_en[0], 0);

    // Mid-period reset, then ramp on dut1
    repeat (37) @(negedge clk);
    reset  = 1'b1;
    duty_s = {7'd40, 7'd35};
    sign_s = 2'b11;
    @(negedge clk);
    chk("midreset_outs_dut0", int'(outs(0)), 0);
    chk("midreset_outs_dut1", int'(outs(1)), 0);
    reset = 1'b0;
    n = 0; s0 = 1'b0; s1 = 1'b0;
    while (!(s0 && s1) && n < 1000) begin
      @(negedge clk);
      n++;
      if (!s0 && ps0) begin s0 = 1'b1; chk("first_ps_after_reset_dut0", n, 100); end
      if (!s1 && ps1) begin s1 = 1'b1; chk("first_ps_after_reset_dut1", n, 300); end
    end
    if (!(s0 && s1)) begin
      n_chk++; n_fail++;
      $display("FAIL first_ps_after_reset timeout actual=0 required=1");
    end
    for (int r = 0; r < 8; r++) begin
      if (r == 4) duty_s = {7'd40, 7'd5};
      measure(1);
      chk($sformatf("ramp_en_ch0_step%0d", r), r_en[0], ramp_exp[r] * 3);
    end
    chk("model_pin_ramp_duty", m_duty[1][0], 5);
    chk("model_pin_jump_duty", m_duty[0][0], 5);
    chk("model_pin_sign", int'(m_sgn[0][0]), 1);

    // Brake during dead time on ch1 of dut0
    measure(0);
    chk("pre_brake_en_ch1", r_en[1], 40);
    chk("pre_brake_a_ch1", r_a[1], 100);
    repeat (10) @(negedge clk);
    sign_s = 2'b01;
    @(negedge clk);
    wait_ps(0);
    repeat (30) @(negedge clk);
    v = outs(0);
    chk("in_dead_ch1", int'(v[1]), 1);
    brake_s = 2'b10;
    @(negedge clk);
    v = outs(0);
    chk("brake_en_ch1", int'(v[3*NCH + 1]), 1);
    chk("brake_a_ch1", int'(v[2*NCH + 1]), 0);
    chk("brake_b_ch1", int'(v[NCH + 1]), 0);
    chk("brake_dead_ch1", int'(v[1]), 0);
    repeat (5) @(negedge clk);
    brake_s = 2'b00;
    @(negedge clk);
    v = outs(0);
    chk("release_en_ch1", int'(v[3*NCH + 1]), 0);
    chk("release_a_kept_ch1", int'(v[2*NCH + 1]), 1);
    measure(0);
    chk("after_brake_en_ch1", r_en[1], 40);
    chk("after_brake_b_ch1", r_b[1], 100);
    chk("after_brake_dead_ch1", r_d[1], 0);

    // Randomised traffic against the model
    for (int t = 0; t < 15000; t++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 4999) == 0);
      if ($urandom_range(0, 149) == 0) begin
        ch = $urandom_range(0, NCH - 1);
        duty_s[ch*W +: W] = ($urandom_range(0, 3) == 0) ? 7'd100 : 7'($urandom_range(0, 127));
      end
      if ($urandom_range(0, 249) == 0) begin
        ch = $urandom_range(0, NCH - 1);
        sign_s[ch] = ~sign_s[ch];
      end
      for (int i = 0; i < NCH; i++) begin
        if (brake_s[i]) begin
          if ($urandom_range(0, 19) == 0) brake_s[i] = 1'b0;
        end else if ($urandom_range(0, 599) == 0) begin
          brake_s[i] = 1'b1;
        end
      end
    end
    reset = 1'b0;
    brake_s = '0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
